floating_point_adder: RTL and testbench



---
 rtl/fp16_pkg.sv | 27 ++
 rtl/fp16_lzc.sv | 23 ++
 rtl/floating_point_adder.sv | 168 ++++++++++++++++
 tb/tb_floating_point_adder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// ============================================================================
// Module   : fp16_pkg
// Brief    : Shared binary16 format constants and adder state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp16_pkg;

  localparam int EXP_W   = 5;
  localparam int FRAC_W  = 10;
  localparam int BIAS    = 15;
  localparam int EXP_MAX = 31;

  localparam logic [15:0] CANON_NAN = 16'h7E00;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fp16_lzc.sv
// ============================================================================
// Module   : fp16_lzc
// Brief    : 14-bit leading-zero counter (returns 14 for an all-zero input).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp16_lzc (
  input  logic [13:0] value,
  output logic [3:0]  count
);

  // Later (higher) set bits overwrite earlier ones, so the MSB-most one wins.
  always_comb begin
    count = 4'd14;
    for (int i = 0; i < 14; i++) begin
      if (value[i]) count = 4'(13 - i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/floating_point_adder.sv
// ============================================================================
// Module   : floating_point_adder
// Brief    : Multi-cycle binary16 adder, flush-to-zero, round-to-nearest-even.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module floating_point_adder
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        add,
  input  logic [15:0] number1,
  input  logic [15:0] number2,
  output logic [15:0] result,
  output logic        ready
);

  // hidden bit + fraction + guard/round/sticky
  localparam int SIG_W = FRAC_W + 4;

  state_t             r_state;
  logic [15:0]        r_op_a, r_op_b;
  logic               r_sign, r_sub, r_special;
  logic [15:0]        r_special_val;
  logic [EXP_W-1:0]   r_exp;
  logic [SIG_W-1:0]   r_sig_a, r_sig_b;
  logic [SIG_W:0]     r_sum;

  logic               w_a_zero, w_b_zero, w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic               w_swap, w_small_zero, w_lost, w_special;
  logic [15:0]        w_big, w_special_val;
  logic [14:0]        w_small, w_mag_a, w_mag_b;
  logic [EXP_W-1:0]   w_diff;
  logic [SIG_W-1:0]   w_small_ext, w_small_al;

  always_comb begin
    w_a_zero = (r_op_a[14:10] == 5'd0);
    w_b_zero = (r_op_b[14:10] == 5'd0);
    w_a_nan  = (&r_op_a[14:10]) && (|r_op_a[9:0]);
    w_b_nan  = (&r_op_b[14:10]) && (|r_op_b[9:0]);
    w_a_inf  = (&r_op_a[14:10]) && !(|r_op_a[9:0]);
    w_b_inf  = (&r_op_b[14:10]) && !(|r_op_b[9:0]);

    w_mag_a      = w_a_zero ? 15'd0 : r_op_a[14:0];
    w_mag_b      = w_b_zero ? 15'd0 : r_op_b[14:0];
    w_swap       = (w_mag_b > w_mag_a);
    w_big        = w_swap ? r_op_b : r_op_a;
    w_small      = w_swap ? r_op_a[14:0] : r_op_b[14:0];
    w_small_zero = w_swap ? w_a_zero : w_b_zero;

    // Shift amounts of 14+ push everything into the sticky bit via the mask.
    w_small_ext = w_small_zero ? '0 : {1'b1, w_small[9:0], 3'b000};
    w_diff      = w_big[14:10] - w_small[14:10];
    w_lost      = |(w_small_ext & ~({SIG_W{1'b1}} << w_diff));
    w_small_al  = (w_small_ext >> w_diff) | {{(SIG_W-1){1'b0}}, w_lost};

    w_special     = 1'b1;
    w_special_val = CANON_NAN;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (r_op_a[15] != r_op_b[15])))
      w_special_val = CANON_NAN;
    else if (w_a_inf)
      w_special_val = r_op_a;
    else if (w_b_inf)
      w_special_val = r_op_b;
    else if (w_a_zero && w_b_zero)
      w_special_val = {r_op_a[15] & r_op_b[15], 15'd0};
    else
      w_special = 1'b0;
  end

  logic [3:0]         w_lz;
  logic [SIG_W-1:0]   w_norm;
  logic [6:0]         w_exp_n, w_exp_f;
  logic               w_round_up;
  logic [FRAC_W+1:0]  w_mant;
  logic [FRAC_W-1:0]  w_frac;
  logic [15:0]        w_norm_res;

  fp16_lzc u_lzc (
    .value (r_sum[SIG_W-1:0]),
    .count (w_lz)
  );

  // Exponent is carried in 7 bits so underflow shows up as a negative value.
  always_comb begin
    if (r_sum[SIG_W]) begin
      w_norm  = {r_sum[SIG_W:2], r_sum[1] | r_sum[0]};
      w_exp_n = {2'b00, r_exp} + 7'd1;
    end else begin
      w_norm  = r_sum[SIG_W-1:0] << w_lz;
      w_exp_n = {2'b00, r_exp} - {3'b000, w_lz};
    end
    w_round_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_mant     = {1'b0, w_norm[SIG_W-1:3]} + {{(FRAC_W+1){1'b0}}, w_round_up};
    w_frac     = w_mant[FRAC_W+1] ? w_mant[FRAC_W:1] : w_mant[FRAC_W-1:0];
    w_exp_f    = w_exp_n + {6'd0, w_mant[FRAC_W+1]};

    if (r_special)
      w_norm_res = r_special_val;
    else if (r_sum == '0)
      w_norm_res = 16'h0000;
    else if (w_exp_f[6] || (w_exp_f == 7'd0))
      w_norm_res = {r_sign, 15'd0};
    else if (w_exp_f >= 7'(EXP_MAX))
      w_norm_res = {r_sign, 5'h1F, 10'd0};
    else
      w_norm_res = {r_sign, w_exp_f[4:0], w_frac};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      result        <= 16'h0000;
      ready         <= 1'b0;
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_sign        <= 1'b0;
      r_sub         <= 1'b0;
      r_special     <= 1'b0;
      r_special_val <= '0;
      r_exp         <= '0;
      r_sig_a       <= '0;
      r_sig_b       <= '0;
      r_sum         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          ready <= 1'b0;
          if (add) begin
            r_op_a  <= number1;
            r_op_b  <= number2;
            r_state <= ALIGN;
          end
        end
        ALIGN: begin
          r_sign        <= w_big[15];
          r_sub         <= r_op_a[15] ^ r_op_b[15];
          r_special     <= w_special;
          r_special_val <= w_special_val;
          r_exp         <= w_big[14:10];
          r_sig_a       <= {1'b1, w_big[9:0], 3'b000};
          r_sig_b       <= w_small_al;
          r_state       <= ADD;
        end
        ADD: begin
          r_sum   <= r_sub ? ({1'b0, r_sig_a} - {1'b0, r_sig_b})
                           : ({1'b0, r_sig_a} + {1'b0, r_sig_b});
          r_state <= NORM;
        end
        NORM: begin
          result  <= w_norm_res;
          ready   <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          ready   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_floating_point_adder.sv
// ============================================================================
// Module   : tb_floating_point_adder
// Brief    : Self-checking bench for the binary16 adder against a real-number model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_floating_point_adder;

  logic        clk;
  logic        rst_n;
  logic        add;
  logic [15:0] number1, number2;
  logic [15:0] result;
  logic        ready;

  int errors = 0;
  int checks = 0;

  floating_point_adder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .add     (add),
    .number1 (number1),
    .number2 (number2),
    .result  (result),
    .ready   (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic real fp16_to_real(input logic [15:0] x);
    real v;
    int  p;
    if (x[14:10] == 5'd0) return 0.0;
    v = 1.0 + real'(int'(x[9:0])) / 1024.0;
    p = int'(x[14:10]) - 15;
    while (p > 0) begin v = v * 2.0; p--; end
    while (p < 0) begin v = v / 2.0; p++; end
    return x[15] ? -v : v;
  endfunction

  // Exact sum in double, then round to 11 significant bits, ties to even.
  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    logic a_nan, b_nan, a_inf, b_inf, neg;
    real  s, m, scaled, rem;
    int   e, q, be;
    a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 0);
    b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 0);
    a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 0);
    b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 0);
    if (a_nan || b_nan) return 16'h7E00;
    if (a_inf && b_inf) return (a[15] != b[15]) ? 16'h7E00 : a;
    if (a_inf) return a;
    if (b_inf) return b;
    if (a[14:10] == 0 && b[14:10] == 0) return {a[15] & b[15], 15'h0};
    s = fp16_to_real(a) + fp16_to_real(b);
    if (s == 0.0) return 16'h0000;
    neg = (s < 0.0);
    m   = neg ? -s : s;
    e   = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    scaled = m * 1024.0;
    q      = $rtoi(scaled);
    rem    = scaled - real'(q);
    if (rem > 0.5 || (rem == 0.5 && (q % 2) == 1)) q++;
    if (q == 2048) begin q = 1024; e++; end
    be = e + 15;
    if (be <= 0)  return {neg, 15'h0};
    if (be >= 31) return {neg, 5'h1F, 10'h0};
    return {neg, 5'(be), 10'(q - 1024)};
  endfunction

  // Issues one request from IDLE; lat counts cycles after the capture edge (0 = timeout).
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] res, output int lat);
    @(negedge clk);
    number1 = a;
    number2 = b;
    add     = 1'b1;
    @(posedge clk);
    lat = 0;
    res = 16'hxxxx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      add = 1'b0;
      if (ready) begin
        lat = i;
        res = result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; add = 1'b0; number1 = 16'h0; number2 = 16'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (result !== 16'h0000) begin errors++; $display("FAIL reset_result got=%h exp=0000", result); end
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_directed();
    logic [15:0] tab_a [12] = '{16'h4C40, 16'h3C00, 16'h3C00, 16'h3C00, 16'h7BFF, 16'h7E00,
                                16'h3C00, 16'h7C00, 16'h7C00, 16'h0000, 16'h8000, 16'h0001};
    logic [15:0] tab_b [12] = '{16'h4C80, 16'hBC00, 16'hB800, 16'h1000, 16'h7BFF, 16'h3C00,
                                16'h7E00, 16'hFC00, 16'h3C00, 16'h8000, 16'h8000, 16'h3C00};
    logic [15:0] tab_r [12] = '{16'h5060, 16'h0000, 16'h3800, 16'h3C00, 16'h7C00, 16'h7E00,
                                16'h7E00, 16'h7E00, 16'h7C00, 16'h0000, 16'h8000, 16'h3C00};
    logic [15:0] res;
    int lat;
    for (int i = 0; i < 12; i++) begin
      do_op(tab_a[i], tab_b[i], res, lat);
      checks++;
      if (res !== tab_r[i]) begin
        errors++; $display("FAIL directed[%0d] %h+%h got=%h exp=%h", i, tab_a[i], tab_b[i], res, tab_r[i]);
      end
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL directed_latency[%0d] got=%0d exp=4", i, lat); end
    end
  endtask

  task automatic test_back_to_back();
    int n_ready = 0;
    int cyc1 = -1, cyc2 = -1;
    logic [15:0] r1 = 16'hxxxx, r2 = 16'hxxxx;
    @(negedge clk);
    number1 = 16'h4C40; number2 = 16'h4C80; add = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (ready) begin
        n_ready++;
        if (n_ready == 1) begin
          cyc1 = i; r1 = result;
          number1 = 16'h4C40; number2 = 16'h4C40;
        end else begin
          cyc2 = i; r2 = result;
          add = 1'b0;
        end
      end
    end
    add = 1'b0;
    checks++;
    if (n_ready !== 2) begin errors++; $display("FAIL b2b_pulses got=%0d exp=2", n_ready); end
    checks++;
    if (r1 !== 16'h5060) begin errors++; $display("FAIL b2b_first got=%h exp=5060", r1); end
    checks++;
    if (r2 !== 16'h5040) begin errors++; $display("FAIL b2b_second got=%h exp=5040", r2); end
    checks++;
    if (cyc1 !== 4 || cyc2 !== 9) begin
      errors++; $display("FAIL b2b_timing got=%0d,%0d exp=4,9", cyc1, cyc2);
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, res, exp_r;
    int lat;
    for (int i = 0; i < 400; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 2 == 0) b[14:10] = a[14:10] ^ 5'($urandom_range(0, 3));
      exp_r = ref_add(a, b);
      do_op(a, b, res, lat);
      checks++;
      if (res !== exp_r || lat !== 4) begin
        errors++; $display("FAIL random %h+%h got=%h lat=%0d exp=%h lat=4", a, b, res, lat, exp_r);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] res;
    int lat;
    logic bad = 1'b0;
    do_op(16'h3C00, 16'h3C00, res, lat);
    repeat (5) @(negedge clk);
    checks++;
    if (result !== 16'h4000) begin errors++; $display("FAIL hold_result got=%h exp=4000", result); end
    @(negedge clk);
    number1 = 16'h4C40; number2 = 16'h4C80; add = 1'b1;
    @(posedge clk);
    @(negedge clk);
    add = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (result !== 16'h0000 || ready !== 1'b0) begin
      errors++; $display("FAIL reset_mid got=%h/%b exp=0000/0", result, ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ready !== 1'b0 || result !== 16'h0000) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL reset_idle got=%h/%b exp=0000/0", result, ready); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
